game_end_of_game_timer: RTL and testbench

Times the end-of-game pause and keeps the match score. Sits directly downstream of the game master FSM: it consumes `end_of_game_timer_start` and `game_won`, returns `end_of_game_timer_running`, and drives win/loss BCD counters and a blink enable for the display/LED stage.

---
 rtl/game_end_of_game_timer_pkg.sv | 32 +++
 rtl/game_bcd_counter_sat.sv | 22 ++
 rtl/game_end_of_game_timer.sv | 126 ++++++++++++
 tb/tb_game_end_of_game_timer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/game_end_of_game_timer_pkg.sv
// Shared constants, state encoding and BCD helper for the end-of-game timer.
// Optional feature macro used by the top: GAME_TIMER_BLINK_EN.
package game_end_of_game_timer_pkg;

    localparam int BCD_DIGIT_W      = 4;
    localparam int DEF_TIMER_CYCLES = 50_000_000;
    localparam int DEF_BLINK_CYCLES = 6_250_000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        SCORE = 2'd2
    } state_t;

    // Two-digit BCD increment that holds at 99.
    function automatic logic [2*BCD_DIGIT_W-1:0] bcd2_inc_sat(
        input logic [2*BCD_DIGIT_W-1:0] value
    );
        logic [BCD_DIGIT_W-1:0] tens;
        logic [BCD_DIGIT_W-1:0] ones;
        tens = value[2*BCD_DIGIT_W-1:BCD_DIGIT_W];
        ones = value[BCD_DIGIT_W-1:0];
        if (tens == BCD_DIGIT_W'(9) && ones == BCD_DIGIT_W'(9)) begin
            return value;
        end
        if (ones == BCD_DIGIT_W'(9)) begin
            return {tens + BCD_DIGIT_W'(1), BCD_DIGIT_W'(0)};
        end
        return {tens, ones + BCD_DIGIT_W'(1)};
    endfunction

endpackage

// File: rtl/game_bcd_counter_sat.sv
// Two-digit saturating BCD score counter; clr has priority over inc.
module game_bcd_counter_sat
    import game_end_of_game_timer_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       inc,
    input  logic                       clr,
    output logic [2*BCD_DIGIT_W-1:0]   value
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc) begin
            value <= bcd2_inc_sat(value);
        end
    end

endmodule

// File: rtl/game_end_of_game_timer.sv
// End-of-game pause timer with win/loss BCD score keeping.
// Define GAME_TIMER_BLINK_EN to build the blink counter; otherwise blink is tied low.
module game_end_of_game_timer
    import game_end_of_game_timer_pkg::*;
#(
    parameter int TIMER_CYCLES = DEF_TIMER_CYCLES,
    parameter int BLINK_CYCLES = DEF_BLINK_CYCLES
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     end_of_game_timer_start,
    input  logic                     game_won,
    input  logic                     clear_score,
    output logic                     end_of_game_timer_running,
    output logic                     round_done,
    output logic [2*BCD_DIGIT_W-1:0] wins_bcd,
    output logic [2*BCD_DIGIT_W-1:0] losses_bcd,
    output logic                     blink
);

    localparam int TW = ($clog2(TIMER_CYCLES) > 1) ? $clog2(TIMER_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMER_CYCLES - 1);

    state_t          state_q;
    state_t          state_d;
    logic [TW-1:0]   count_q;
    logic            won_q;
    logic            score_win;
    logic            score_loss;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (end_of_game_timer_start) state_d = RUN;
            RUN:     if (count_q == '0) state_d = SCORE;
            SCORE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Start is only honoured from IDLE, so a repeated pulse never reloads the pause.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            won_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (end_of_game_timer_start) count_q <= TIMER_LOAD;
                end
                RUN: begin
                    if (count_q == '0) begin
                        won_q <= game_won;
                    end else begin
                        count_q <= count_q - TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Start is ORed in so the master sees running in the same cycle as its own pulse.
    assign end_of_game_timer_running = end_of_game_timer_start | (state_q == RUN);
    assign round_done                = (state_q == SCORE);
    assign score_win                 = round_done & won_q;
    assign score_loss                = round_done & ~won_q;

    game_bcd_counter_sat u_wins (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (score_win),
        .clr     (clear_score),
        .value   (wins_bcd)
    );

    game_bcd_counter_sat u_losses (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (score_loss),
        .clr     (clear_score),
        .value   (losses_bcd)
    );

`ifdef GAME_TIMER_BLINK_EN
    localparam int BW = ($clog2(BLINK_CYCLES) > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_CYCLES - 1);

    logic [BW-1:0] blink_cnt_q;
    logic          blink_q;

    // Blink starts high on entry to RUN and is cleared on any cycle leaving RUN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else if (state_q == IDLE && end_of_game_timer_start) begin
            blink_cnt_q <= BLINK_LOAD;
            blink_q     <= 1'b1;
        end else if (state_q == RUN && state_d == RUN) begin
            if (blink_cnt_q == '0) begin
                blink_cnt_q <= BLINK_LOAD;
                blink_q     <= ~blink_q;
            end else begin
                blink_cnt_q <= blink_cnt_q - BW'(1);
            end
        end else begin
            blink_q <= 1'b0;
        end
    end

    assign blink = blink_q;
`else
    // Constant low; the parameter is still referenced so both builds share one interface.
    assign blink = (BLINK_CYCLES < 0);
`endif

endmodule

// File: tb/tb_game_end_of_game_timer.sv
// Directed self-checking bench for game_end_of_game_timer (TIMER_CYCLES=10, BLINK_CYCLES=3).
// Blink expectations follow GAME_TIMER_BLINK_EN as compiled.
module tb_game_end_of_game_timer;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       game_won;
    logic       clear_score;
    logic       running;
    logic       round_done;
    logic [7:0] wins_bcd;
    logic [7:0] losses_bcd;
    logic       blink;

    int vectors;
    int miscompares;

    game_end_of_game_timer #(
        .TIMER_CYCLES (10),
        .BLINK_CYCLES (3)
    ) dut (
        .clk                       (clk),
        .reset_n                   (reset_n),
        .end_of_game_timer_start   (start),
        .game_won                  (game_won),
        .clear_score               (clear_score),
        .end_of_game_timer_running (running),
        .round_done                (round_done),
        .wins_bcd                  (wins_bcd),
        .losses_bcd                (losses_bcd),
        .blink                     (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, actual, expected);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(n / 10);
        ones = 4'(n % 10);
        return {tens, ones};
    endfunction

    // Cycle 0 is the start-pulse cycle; RUN occupies cycles 1..10.
    function automatic logic exp_blink(input int c);
`ifdef GAME_TIMER_BLINK_EN
        if (c >= 1 && c <= 10) return (((c - 1) / 3) % 2) == 0;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    // One full round of 13 cycles, entered and left just after a rising edge.
    task automatic play_round(
        input logic       won,
        input logic       only_last,
        input int         restart_cyc,
        input int         clear_cyc,
        input logic [7:0] prev_w,
        input logic [7:0] prev_l,
        input logic [7:0] exp_w,
        input logic [7:0] exp_l
    );
        for (int c = 0; c <= 12; c++) begin
            start       = (c == 0) || (c == restart_cyc);
            game_won    = (only_last && c != 10) ? ~won : won;
            clear_score = (c == clear_cyc);
            @(negedge clk);
            check_output("running", 32'(running), 32'((c <= 10) || start));
            check_output("round_done", 32'(round_done), 32'(c == 11));
            check_output("blink", 32'(blink), 32'(exp_blink(c)));
            if (c <= 11) begin
                check_output("wins_hold", 32'(wins_bcd), 32'(prev_w));
                check_output("losses_hold", 32'(losses_bcd), 32'(prev_l));
            end else begin
                check_output("wins", 32'(wins_bcd), 32'(exp_w));
                check_output("losses", 32'(losses_bcd), 32'(exp_l));
            end
            @(posedge clk);
            #1;
        end
        start       = 1'b0;
        clear_score = 1'b0;
    endtask

    task automatic reset_mid_run();
        start    = 1'b1;
        game_won = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #1;
        check_output("running_pre_reset", 32'(running), 32'd1);
        reset_n = 1'b0;
        #1;
        check_output("running_in_reset", 32'(running), 32'd0);
        check_output("blink_in_reset", 32'(blink), 32'd0);
        check_output("round_done_in_reset", 32'(round_done), 32'd0);
        check_output("wins_in_reset", 32'(wins_bcd), 32'h00);
        check_output("losses_in_reset", 32'(losses_bcd), 32'h00);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            check_output("running_after_reset", 32'(running), 32'd0);
            check_output("round_done_after_reset", 32'(round_done), 32'd0);
            check_output("wins_after_reset", 32'(wins_bcd), 32'h00);
            check_output("losses_after_reset", 32'(losses_bcd), 32'h00);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        start       = 1'b0;
        game_won    = 1'b0;
        clear_score = 1'b0;

        #3;
        check_output("reset_running", 32'(running), 32'd0);
        check_output("reset_round_done", 32'(round_done), 32'd0);
        check_output("reset_blink", 32'(blink), 32'd0);
        check_output("reset_wins", 32'(wins_bcd), 32'h00);
        check_output("reset_losses", 32'(losses_bcd), 32'h00);
        #9;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        play_round(1'b1, 1'b0, -1, -1, 8'h00, 8'h00, 8'h01, 8'h00);
        play_round(1'b1, 1'b1, -1, -1, 8'h01, 8'h00, 8'h02, 8'h00);
        play_round(1'b0, 1'b1, -1, -1, 8'h02, 8'h00, 8'h02, 8'h01);
        play_round(1'b1, 1'b0,  5, -1, 8'h02, 8'h01, 8'h03, 8'h01);
        play_round(1'b0, 1'b0, 11, -1, 8'h03, 8'h01, 8'h03, 8'h02);
        play_round(1'b1, 1'b0, -1, 11, 8'h03, 8'h02, 8'h00, 8'h00);

        for (int i = 1; i <= 9; i++) begin
            play_round(1'b1, 1'b0, -1, -1, to_bcd(i - 1), 8'h00, to_bcd(i), 8'h00);
        end
        play_round(1'b1, 1'b0, -1, -1, 8'h09, 8'h00, 8'h10, 8'h00);
        for (int i = 11; i <= 99; i++) begin
            play_round(1'b1, 1'b0, -1, -1, to_bcd(i - 1), 8'h00, to_bcd(i), 8'h00);
        end
        play_round(1'b1, 1'b0, -1, -1, 8'h99, 8'h00, 8'h99, 8'h00);
        play_round(1'b0, 1'b0, -1, -1, 8'h99, 8'h00, 8'h99, 8'h01);

        reset_mid_run();
        play_round(1'b1, 1'b0, -1, -1, 8'h00, 8'h00, 8'h01, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
